// File: rtl/rtc_mux_bus_burst.sv
// Burst transaction engine for the RTC multiplexed A/D bus with active-low CS/RD/WR/AD strobes.
// Optional IRQ-triggered auto-read is enabled by defining RTC_IRQ_AUTOREAD_EN.
module rtc_mux_bus_burst #(
  parameter int DW        = 8,
  parameter int T_PHASE   = 10,
  parameter int MAX_BURST = 8,
  parameter int LW        = $clog2(MAX_BURST + 1)
`ifdef RTC_IRQ_AUTOREAD_EN
  ,
  parameter logic [DW-1:0] IRQ_BASE = 'h21,
  parameter int            IRQ_LEN  = 3
`endif
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic          rw,
  input  logic [DW-1:0] base_addr,
  input  logic [LW-1:0] len,
  input  logic [DW-1:0] wdata,
  output logic          wdata_rd,
  output logic [DW-1:0] rdata,
  output logic          rdata_vld,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] bus_out,
  output logic          bus_oe,
  input  logic [DW-1:0] bus_in,
  output logic          CS,
  output logic          RD,
  output logic          WR,
  output logic          AD
`ifdef RTC_IRQ_AUTOREAD_EN
  ,
  input  logic          irq
`endif
);

  localparam int PW = (T_PHASE > 1) ? $clog2(T_PHASE) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(T_PHASE - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);
  localparam logic [LW-1:0] L_MAX  = LW'(MAX_BURST);
  localparam logic [LW-1:0] L_ONE  = LW'(1);
  localparam logic [DW-1:0] A_ONE  = DW'(1);

  typedef enum logic [2:0] {IDLE, A_LO, A_HI, D_LO, D_HI, FIN} state_t;

  state_t        state, state_n;
  logic [PW-1:0] pcnt;
  logic [DW-1:0] addr, addr_n;
  logic [LW-1:0] cnt, cnt_n;
  logic          rw_q, rw_n;
  logic          phase_end;
  logic          step;
  logic          go;
  logic          go_rw;
  logic [DW-1:0] go_addr;
  logic [LW-1:0] go_len;
  logic          capture_w;
  logic          sample_r;

  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] l);
    return (l > L_MAX) ? L_MAX : l;
  endfunction

  // Strobe/drive pattern for a state: {CS, RD, WR, AD, bus_oe}.
  function automatic logic [4:0] strobes(input state_t s, input logic r);
    case (s)
      A_LO:    return 5'b01001;
      A_HI:    return 5'b01101;
      D_LO:    return r ? 5'b00110 : 5'b01011;
      default: return 5'b11110;
    endcase
  endfunction

`ifdef RTC_IRQ_AUTOREAD_EN
  localparam logic [LW-1:0] IRQ_L = (IRQ_LEN > MAX_BURST) ? L_MAX : LW'(IRQ_LEN);

  logic irq_p0;
  logic pend;
  logic pend_take;

  assign pend_take = (state == IDLE) && !start && pend;

  // A new edge arriving in the launch cycle re-arms the flag rather than being lost.
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_p0 <= 1'b0;
      pend   <= 1'b0;
    end else begin
      irq_p0 <= irq;
      if (irq && !irq_p0)
        pend <= 1'b1;
      else if (pend_take)
        pend <= 1'b0;
    end
  end
`endif

  always_comb begin
    go      = 1'b0;
    go_rw   = rw;
    go_addr = base_addr;
    go_len  = clamp_len(len);
    if (state == IDLE) begin
      if (start) begin
        go = 1'b1;
`ifdef RTC_IRQ_AUTOREAD_EN
      end else if (pend) begin
        go      = 1'b1;
        go_rw   = 1'b1;
        go_addr = IRQ_BASE;
        go_len  = IRQ_L;
`endif
      end
    end
  end

  assign phase_end = (pcnt == P_LAST);
  assign step      = (state == D_HI) && phase_end && (cnt > L_ONE);

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (go) state_n = (go_len == '0) ? FIN : A_LO;
      A_LO: if (phase_end) state_n = A_HI;
      A_HI: if (phase_end) state_n = D_LO;
      D_LO: if (phase_end) state_n = D_HI;
      D_HI: if (phase_end) state_n = step ? A_LO : FIN;
      FIN:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    rw_n   = rw_q;
    addr_n = addr;
    cnt_n  = cnt;
    if (state == IDLE && go) begin
      rw_n   = go_rw;
      addr_n = go_addr;
      cnt_n  = go_len;
    end else if (step) begin
      addr_n = addr + A_ONE;
      cnt_n  = cnt - L_ONE;
    end
  end

  assign capture_w = (state == A_HI) && (state_n == D_LO) && !rw_q;
  assign sample_r  = (state == D_LO) && (state_n == D_HI) && rw_q;

  assign busy = (state == A_LO) || (state == A_HI) || (state == D_LO) || (state == D_HI);
  assign done = (state == FIN);

  // Strobes and drive enable are registered from the next state so the pad sees glitch-free edges.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      pcnt      <= '0;
      rw_q      <= 1'b0;
      addr      <= '0;
      cnt       <= '0;
      CS        <= 1'b1;
      RD        <= 1'b1;
      WR        <= 1'b1;
      AD        <= 1'b1;
      bus_oe    <= 1'b0;
      bus_out   <= '0;
      rdata     <= '0;
      rdata_vld <= 1'b0;
      wdata_rd  <= 1'b0;
    end else begin
      state <= state_n;
      pcnt  <= ((state_n != state) || (state == IDLE)) ? '0 : pcnt + P_ONE;
      rw_q  <= rw_n;
      addr  <= addr_n;
      cnt   <= cnt_n;
      {CS, RD, WR, AD, bus_oe} <= strobes(state_n, rw_n);
      if (state_n == A_LO && state != A_LO)
        bus_out <= addr_n;
      else if (capture_w)
        bus_out <= wdata;
      wdata_rd  <= capture_w;
      rdata_vld <= sample_r;
      if (sample_r)
        rdata <= bus_in;
    end
  end

endmodule

// File: tb/tb_rtc_mux_bus_burst.sv
// Randomised bench for rtc_mux_bus_burst with a behavioural RTC register model on the bus.
module tb_rtc_mux_bus_burst;
  localparam int DW = 8;
  localparam int TP = 2;
  localparam int MB = 8;
  localparam int LW = $clog2(MB + 1);

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start = 1'b0;
  logic          rw = 1'b0;
  logic [DW-1:0] base_addr = '0;
  logic [LW-1:0] len = '0;
  logic [DW-1:0] wdata = '0;
  logic          wdata_rd;
  logic [DW-1:0] rdata;
  logic          rdata_vld;
  logic          busy;
  logic          done;
  logic [DW-1:0] bus_out;
  logic          bus_oe;
  logic [DW-1:0] bus_in;
  logic          CS, RD, WR, AD;
`ifdef RTC_IRQ_AUTOREAD_EN
  logic          irq = 1'b0;
`endif

  rtc_mux_bus_burst #(.DW(DW), .T_PHASE(TP), .MAX_BURST(MB), .LW(LW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .rw(rw), .base_addr(base_addr), .len(len),
    .wdata(wdata), .wdata_rd(wdata_rd), .rdata(rdata), .rdata_vld(rdata_vld),
    .busy(busy), .done(done), .bus_out(bus_out), .bus_oe(bus_oe), .bus_in(bus_in),
    .CS(CS), .RD(RD), .WR(WR), .AD(AD)
`ifdef RTC_IRQ_AUTOREAD_EN
    , .irq(irq)
`endif
  );

  always #5 CLK = ~CLK;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RTC model: registers, latched address, and a record of writes it received.
  logic [7:0] mem [256];
  logic [7:0] wmem [256];
  logic [7:0] lat = '0;
  assign bus_in = mem[lat];

  logic [7:0] addr_q[$], wdat_q[$], rdat_q[$], wfix[$];
  int rd_ph, wrd, csl, busyc, donec, viol;
  logic p_cs = 1'b1, p_rd = 1'b1, p_wr = 1'b1, p_ad = 1'b1;
  logic [7:0] p_bus = '0;

  always @(negedge CLK) begin
    if (!CS && !AD && !WR && !(!p_cs && !p_ad && !p_wr)) begin
      addr_q.push_back(bus_out);
      if (!bus_oe) viol++;
    end
    if (!CS && AD && !WR && p_wr) begin
      wdat_q.push_back(bus_out);
      if (!bus_oe) viol++;
    end
    if (!RD && p_rd) begin
      rd_ph++;
      if (bus_oe) viol++;
    end
    if (!p_wr && WR) begin
      if (!AD) lat = bus_out;
      else wmem[lat] = p_bus;
    end
    if (rdata_vld) rdat_q.push_back(rdata);
    if (wdata_rd) wrd++;
    if (!CS) csl++;
    if (busy) busyc++;
    if (done) donec++;
    if (!RD && !WR) viol++;
    if (AD != p_ad && !(p_rd && p_wr)) viol++;
    p_cs = CS; p_rd = RD; p_wr = WR; p_ad = AD; p_bus = bus_out;
  end

  function automatic logic [31:0] qget(input logic [7:0] q[$], input int i);
    return (i < q.size()) ? {24'd0, q[i]} : 32'hDEAD;
  endfunction

  task automatic clear_mon();
    addr_q = {}; wdat_q = {}; rdat_q = {};
    rd_ph = 0; wrd = 0; csl = 0; busyc = 0; donec = 0; viol = 0;
  endtask

  task automatic run_burst(input logic r, input logic [7:0] base, input logic [LW-1:0] l,
                           input bit poke, input bit irqp, input bit idle_chk);
    int n, cyc, widx;
    bit got;
    logic [7:0] wq[$];
    logic [7:0] a;
    n = (int'(l) > MB) ? MB : int'(l);
    wq = {};
    for (int i = 0; i < n; i++)
      wq.push_back((i < wfix.size()) ? wfix[i] : 8'($urandom));
    @(posedge CLK); #1;
    clear_mon();
    @(negedge CLK);
    rw = r; base_addr = base; len = l; start = 1'b1;
    wdata = (n > 0) ? wq[0] : 8'h00;
    @(posedge CLK); #1;
    start = 1'b0; rw = 1'($urandom); base_addr = 8'($urandom); len = LW'($urandom);
    cyc = 0; got = 0; widx = 0;
    while (!got && cyc < 2000) begin
      @(negedge CLK);
      cyc++;
      if (done) got = 1;
      if (wdata_rd) begin
        widx++;
        wdata = (widx < n) ? wq[widx] : 8'($urandom);
      end
      if (poke && cyc == 5) begin
        start = 1'b1; rw = ~r; base_addr = base + 8'h40; len = LW'(5);
      end
      if (poke && cyc == 6) start = 1'b0;
`ifdef RTC_IRQ_AUTOREAD_EN
      irq = irqp && (cyc == 3 || cyc == 12);
`endif
    end
`ifdef RTC_IRQ_AUTOREAD_EN
    irq = 1'b0;
`endif
    check("done_lat", got ? cyc : 32'hFFFF_FFFF, 4 * TP * n + 1);
    repeat (idle_chk ? 3 : 1) @(negedge CLK);
    check("done_cnt", donec, 1);
    check("addr_cnt", addr_q.size(), n);
    for (int i = 0; i < n; i++) begin
      a = base + 8'(i);
      check($sformatf("addr%0d", i), qget(addr_q, i), {24'd0, a});
      if (r) begin
        check($sformatf("rdata%0d", i), qget(rdat_q, i), {24'd0, mem[a]});
      end else begin
        check($sformatf("wbus%0d", i), qget(wdat_q, i), {24'd0, wq[i]});
        check($sformatf("wmem%0d", i), {24'd0, wmem[a]}, {24'd0, wq[i]});
      end
    end
    check("rvld_cnt", rdat_q.size(), r ? n : 0);
    check("wdrd_cnt", wrd, r ? 0 : n);
    check("rd_phases", rd_ph, r ? n : 0);
    check("bus_rules", viol, 0);
    if (idle_chk) check("idle_after", busy, 0);
    if (n == 0) begin
      check("len0_cs", csl, 0);
      check("len0_busy", busyc, 0);
    end
  endtask

  initial begin
    int cyc;
    bit got;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'(i + 16);
      wmem[i] = 8'h00;
    end
    wfix = {};
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("rst_ctrl", {23'd0, CS, RD, WR, AD, bus_oe, busy, done, rdata_vld, wdata_rd}, 32'h1E0);
    check("rst_bus", bus_out, 0);
    check("rst_rdata", rdata, 0);

    run_burst(1'b1, 8'h21, LW'(3), 0, 0, 1);
    wfix = {8'hAA, 8'h55};
    run_burst(1'b0, 8'hFF, LW'(2), 0, 0, 1);
    wfix = {};
    run_burst(1'b1, 8'h50, LW'(0), 0, 0, 1);
    run_burst(1'b1, 8'hF9, LW'(15), 0, 0, 1);
    run_burst(1'b0, 8'h80, LW'(4), 1, 0, 1);

    // Reset asserted during the address phase of a write burst.
    @(negedge CLK);
    clear_mon();
    rw = 1'b0; base_addr = 8'h40; len = LW'(4); start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
    @(negedge CLK);
    check("pre_rst_cs", CS, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    check("mid_rst", {26'd0, CS, RD, WR, AD, bus_oe, busy}, 32'h3C);
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (10) @(negedge CLK);
    check("mid_rst_done", donec, 0);
    check("mid_rst_busy", busy, 0);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      run_burst(1'($urandom_range(0, 1)), 8'($urandom), LW'($urandom_range(0, 15)), 0, 0, 1);
    end

`ifdef RTC_IRQ_AUTOREAD_EN
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    run_burst(1'b0, 8'h10, LW'(3), 0, 1, 0);
    clear_mon();
    cyc = 0; got = 0;
    while (!got && cyc < 500) begin
      @(negedge CLK);
      cyc++;
      if (done) got = 1;
    end
    check("irq_done", got, 1);
    @(negedge CLK);
    check("irq_addr_cnt", addr_q.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("irq_addr%0d", i), qget(addr_q, i), 32'h21 + i);
      check($sformatf("irq_rdata%0d", i), qget(rdat_q, i), {24'd0, mem[8'h21 + i]});
    end
    check("irq_rd_phases", rd_ph, 3);
    csl = 0;
    repeat (100) @(negedge CLK);
    check("irq_once", csl, 0);
`else
    cyc = 0; got = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
